// File: rtl/regfile_sb.sv
// Register file with a pending-write scoreboard and a post-reset sweep that
// zeroes every register and pending bit before raising ready.
module regfile_sb #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int BYPASS = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addrSource,
  input  logic [ADDR_W-1:0] addrTarget,
  output logic [DATA_W-1:0] regSource,
  output logic [DATA_W-1:0] regTarget,
  input  logic              regWrite,
  input  logic [ADDR_W-1:0] addrDestination,
  input  logic [DATA_W-1:0] writeData,
  input  logic              issueValid,
  input  logic [ADDR_W-1:0] issueDest,
  output logic              srcPending,
  output logic              tgtPending,
  output logic              ready
);
  localparam int DEPTH = 2**ADDR_W;

  typedef enum logic {CLEAR, RUN} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [DEPTH-1:0]  pend_q, pend_d;
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              run, wr_live;

  // Outputs are held quiet while rst is sampled high, not only after the edge.
  assign run     = (state_q == RUN) && !rst;
  assign wr_live = regWrite && (addrDestination != '0);
  assign ready   = run;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    wr_en   = 1'b0;
    wr_addr = addrDestination;
    wr_data = writeData;
    case (state_q)
      CLEAR: begin
        wr_en          = 1'b1;
        wr_addr        = cnt_q;
        wr_data        = '0;
        pend_d[cnt_q]  = 1'b0;
        cnt_d          = cnt_q + 1'b1;
        if (cnt_q == '1) state_d = RUN;
      end
      RUN: begin
        if (wr_live) begin
          wr_en                   = 1'b1;
          pend_d[addrDestination] = 1'b0;
        end
        // Issue is applied after the write-clear so it wins on a collision.
        if (issueValid && (issueDest != '0)) pend_d[issueDest] = 1'b1;
      end
      default: state_d = CLEAR;
    endcase
    pend_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && wr_en) mem_q[wr_addr] <= wr_data;
  end

  function automatic logic [DATA_W-1:0] rd_data(input logic [ADDR_W-1:0] a);
    if (!run)                                           return '0;
    if ((BYPASS != 0) && wr_live && (addrDestination == a)) return writeData;
    if (a == '0)                                        return '0;
    return mem_q[a];
  endfunction

  function automatic logic rd_pend(input logic [ADDR_W-1:0] a);
    if (!run)                                           return 1'b0;
    if ((BYPASS != 0) && wr_live && (addrDestination == a)) return 1'b0;
    return pend_q[a];
  endfunction

  assign regSource  = rd_data(addrSource);
  assign regTarget  = rd_data(addrTarget);
  assign srcPending = rd_pend(addrSource);
  assign tgtPending = rd_pend(addrTarget);
endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: bypassing and non-bypassing instances share stimulus
// and are compared against an abstract register/pending model every cycle.
module tb_regfile_sb;
  localparam int DW = 32, AW = 5, DEPTH = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, reg_write, issue_valid;
  logic [AW-1:0] a_s, a_t, a_d, a_i;
  logic [DW-1:0] wdata;

  logic [DW-1:0] rs_b, rt_b, rs_n, rt_n;
  logic          sp_b, tp_b, rdy_b, sp_n, tp_n, rdy_n;

  regfile_sb #(.DATA_W(DW), .ADDR_W(AW), .BYPASS(1)) u_byp (
    .clk(clk), .rst(rst), .addrSource(a_s), .addrTarget(a_t),
    .regSource(rs_b), .regTarget(rt_b), .regWrite(reg_write),
    .addrDestination(a_d), .writeData(wdata), .issueValid(issue_valid),
    .issueDest(a_i), .srcPending(sp_b), .tgtPending(tp_b), .ready(rdy_b));

  regfile_sb #(.DATA_W(DW), .ADDR_W(AW), .BYPASS(0)) u_nobyp (
    .clk(clk), .rst(rst), .addrSource(a_s), .addrTarget(a_t),
    .regSource(rs_n), .regTarget(rt_n), .regWrite(reg_write),
    .addrDestination(a_d), .writeData(wdata), .issueValid(issue_valid),
    .issueDest(a_i), .srcPending(sp_n), .tgtPending(tp_n), .ready(rdy_n));

  int checks = 0, errors = 0;

  // Model: register contents, pending flags, and cycles left until ready.
  logic [DW-1:0] m_mem  [DEPTH];
  bit            m_pend [DEPTH];
  int            clr_left = DEPTH;
  bit            started  = 0;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit m_ready();
    return !rst && (clr_left == 0);
  endfunction

  function automatic bit fwd(input bit byp, input logic [AW-1:0] a);
    return byp && reg_write && (a_d != 0) && (a_d == a);
  endfunction

  function automatic logic [DW-1:0] exp_rd(input bit byp, input logic [AW-1:0] a);
    if (!m_ready()) return '0;
    if (fwd(byp, a)) return wdata;
    if (a == 0)      return '0;
    return m_mem[a];
  endfunction

  function automatic logic exp_pd(input bit byp, input logic [AW-1:0] a);
    if (!m_ready() || fwd(byp, a)) return 1'b0;
    return m_pend[a];
  endfunction

  task automatic sample();
    #3;
    if (started) begin
      chk("ready_byp",   rdy_b, m_ready());
      chk("ready_nobyp", rdy_n, m_ready());
      chk("rs_byp",   rs_b, exp_rd(1, a_s));
      chk("rt_byp",   rt_b, exp_rd(1, a_t));
      chk("sp_byp",   sp_b, exp_pd(1, a_s));
      chk("tp_byp",   tp_b, exp_pd(1, a_t));
      chk("rs_nobyp", rs_n, exp_rd(0, a_s));
      chk("rt_nobyp", rt_n, exp_rd(0, a_t));
      chk("sp_nobyp", sp_n, exp_pd(0, a_s));
      chk("tp_nobyp", tp_n, exp_pd(0, a_t));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) begin
      clr_left = DEPTH;
      started  = 1;
    end else if (started && clr_left > 0) begin
      clr_left--;
      if (clr_left == 0)
        for (int k = 0; k < DEPTH; k++) begin m_mem[k] = '0; m_pend[k] = 0; end
    end else if (started) begin
      if (reg_write && a_d != 0) begin m_mem[a_d] = wdata; m_pend[a_d] = 0; end
      if (issue_valid && a_i != 0) m_pend[a_i] = 1;
    end
    #1;
  endtask

  task automatic step();
    sample();
    tick();
  endtask

  task automatic idle();
    reg_write = 0; issue_valid = 0; a_d = '0; a_i = '0; wdata = '0;
  endtask

  task automatic rand_in(input int amax);
    a_s         = AW'($urandom_range(0, amax));
    a_t         = AW'($urandom_range(0, amax));
    a_d         = AW'($urandom_range(0, amax));
    a_i         = AW'($urandom_range(0, amax));
    reg_write   = 1'($urandom_range(0, 1));
    issue_valid = 1'($urandom_range(0, 1));
    wdata       = $urandom;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    reg_write = 1; a_d = a; wdata = d;
    step();
    idle();
  endtask

  initial begin
    int n;
    rst = 0; a_s = '0; a_t = '0;
    idle();
    #1;
    rst = 1; step(); rst = 0;

    // Clear sweep with live write/issue traffic that must be ignored.
    n = 0;
    for (n = 0; n < 40; n++) begin
      rand_in(31);
      sample();
      if (rdy_b) break;
      tick();
    end
    chk("clear_latency", n, 32);
    idle(); tick();

    for (int i = 0; i < DEPTH; i++) begin
      a_s = AW'(i); a_t = AW'(DEPTH - 1 - i);
      sample(); chk("swept_zero", rs_b, 32'h0); tick();
    end

    wr(5, 32'hDEADBEEF);
    a_s = 5; sample(); chk("r5_read", rs_b, 32'hDEADBEEF); tick();
    wr(0, 32'h12345678);
    a_s = 0; a_t = 0; sample(); chk("r0_read", rs_n, 32'h0); tick();

    wr(7, 32'h11111111);
    a_s = 7; reg_write = 1; a_d = 7; wdata = 32'hA5A5A5A5;
    sample();
    chk("byp_same_cycle", rs_b, 32'hA5A5A5A5);
    chk("nobyp_old",      rs_n, 32'h11111111);
    tick(); idle();
    sample(); chk("nobyp_next", rs_n, 32'hA5A5A5A5); tick();

    a_s = 9; a_t = 9; issue_valid = 1; a_i = 9;
    step(); idle();
    sample(); chk("pend_set", sp_b, 1); chk("pend_set_t", tp_n, 1); tick();
    reg_write = 1; a_d = 9; wdata = 32'h99;
    sample(); chk("pend_fwd_clear", sp_b, 0); chk("pend_nofwd", sp_n, 1); tick(); idle();
    sample(); chk("pend_cleared", sp_n, 0); tick();
    reg_write = 1; a_d = 9; wdata = 32'h999; issue_valid = 1; a_i = 9;
    step(); idle();
    sample(); chk("issue_wins", sp_b, 1); chk("issue_wins_data", rs_n, 32'h999); tick();
    issue_valid = 1; a_i = 0; a_s = 0; step(); idle();
    sample(); chk("pend0", sp_b, 0); tick();

    for (int c = 0; c < 400; c++) begin
      rand_in(c < 200 ? 7 : 31);
      rst = ($urandom_range(0, 149) == 0);
      step();
    end
    rst = 0; idle();
    repeat (DEPTH + 2) step();

    // Reset mid-clear: writes during the clear must not survive it.
    wr(3, 32'h55);
    a_s = 3; sample(); chk("r3_before", rs_b, 32'h55); tick();
    rst = 1; step(); rst = 0;
    repeat (10) begin rand_in(31); step(); end
    rst = 1; idle(); step(); rst = 0;
    for (n = 0; n < 40; n++) begin
      reg_write = 1; a_d = 3; wdata = 32'h77; a_s = 3;
      sample();
      if (rdy_b) break;
      tick();
    end
    chk("restart_latency", n, 32);
    idle(); a_s = 3; a_t = 3;
    sample(); chk("r3_cleared", rs_b, 32'h0); chk("r3_cleared_t", rt_n, 32'h0); tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/regfile_sb.md
REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning register width in bits.
REQ-002 SHALL have parameter ADDR_W, default 5, meaning register address width; DEPTH = 2**ADDR_W registers.
REQ-003 SHALL have parameter BYPASS, default 1, meaning 1 enables write-to-read forwarding, 0 disables it.
REQ-004 SHALL have port clk  input  1  rising-edge clock; the only clock.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-006 SHALL have ports addrSource, addrTarget  input  ADDR_W  read addresses for read ports S and T.
REQ-007 SHALL have ports regSource, regTarget  output  DATA_W  combinational read data for ports S and T.
REQ-008 SHALL have ports regWrite  input  1, addrDestination  input  ADDR_W, writeData  input  DATA_W  writeback port.
REQ-009 SHALL have ports issueValid  input  1, issueDest  input  ADDR_W  mark a destination register as pending.
REQ-010 SHALL have ports srcPending, tgtPending  output  1  scoreboard pending flag for addrSource and addrTarget.
REQ-011 SHALL have port ready  output  1  1 when the post-reset clear has completed.

Function
REQ-012 SHALL implement a two-state FSM, CLEAR and RUN; rst forces CLEAR with the clear counter at 0.
REQ-013 In CLEAR, SHALL write 0 to register[counter] and clear pending[counter] once per cycle, then increment the counter.
REQ-014 SHALL go from CLEAR to RUN on the cycle that clears register DEPTH-1, so ready rises exactly DEPTH cycles after rst deasserts.
REQ-015 While in CLEAR, SHALL ignore regWrite and issueValid, drive regSource/regTarget = 0, and drive srcPending/tgtPending = 0.
REQ-016 rst asserted mid-CLEAR or in RUN SHALL restart the clear from register 0 on the next edge.
REQ-017 In RUN, regWrite=1 with addrDestination != 0 SHALL store writeData at the next rising edge.
REQ-018 A write to register 0 SHALL be discarded; reads of address 0 SHALL always return 0.
REQ-019 Reads SHALL be combinational from the array, with 0-cycle latency.
REQ-020 With BYPASS=1 in RUN, if regWrite=1, addrDestination != 0 and addrDestination equals a read address, that port SHALL return writeData in the same cycle.
REQ-021 With BYPASS=0, reads SHALL return the stored value until the edge after the write.
REQ-022 In RUN, issueValid=1 with issueDest != 0 SHALL set pending[issueDest] at the next edge.
REQ-023 In RUN, regWrite=1 with addrDestination != 0 SHALL clear pending[addrDestination] at the next edge.
REQ-024 When an issue and a write target the same register in the same cycle, pending SHALL end set (issue wins); the data write SHALL still occur.
REQ-025 pending[0] SHALL be constant 0; issueDest=0 SHALL have no effect.
REQ-026 srcPending SHALL be pending[addrSource], and tgtPending SHALL be pending[addrTarget].
REQ-027 With BYPASS=1, srcPending/tgtPending SHALL be forced to 0 when the same-cycle write matches the address.
REQ-028 Both read ports SHALL be independent; identical addresses on S and T SHALL return identical data and flags.

Reset
REQ-029 During the cycle rst is sampled high and the following CLEAR cycles, ready SHALL be 0, regSource/regTarget SHALL be 0, and srcPending/tgtPending SHALL be 0.
REQ-030 After ready rises, every register SHALL read 0 and every pending bit SHALL be 0.
REQ-031 Array contents before the first rst SHALL be treated as undefined; ready SHALL be 0 until the first clear completes.

Verification
REQ-032 Reset clear: pulse rst 1 cycle (default parameters) -> ready=0 for 32 cycles, ready=1 on cycle 33; all 32 addresses read 0x00000000.
REQ-033 Write/read and zero register:
- write 0xDEADBEEF to r5, then read S=5 -> 0xDEADBEEF the next cycle;
- write 0x12345678 to r0, then read r0 -> 0x00000000.
REQ-034 Bypass: BYPASS=1, regWrite r7=0xA5A5A5A5 with addrSource=7 in the same cycle -> regSource=0xA5A5A5A5 that cycle. BYPASS=0, same stimulus -> old value that cycle and 0xA5A5A5A5 the next cycle.
REQ-035 Scoreboard: issue r9 -> srcPending=1 for addrSource=9 from the next cycle; write r9 -> flag 0 (same cycle if BYPASS=1, next cycle otherwise). Issue r9 and write r9 together -> pending stays 1.
REQ-036 Reset mid-operation: write r3=0x55, assert rst at clear counter 10 of a prior clear -> clear restarts, ready rises 32 cycles after rst drops, r3 reads 0, and regWrite during CLEAR has no effect.
